smem_output_arbiter: RTL and testbench

- Shares one downstream 512-bit result stream among NUM_PORTS batch-result buffers. Each buffer holds per-read mem/curr queues and drives an output_request / output_permit / output_valid / output_finish interface.
- Grants one buffer at a time in round-robin order, holds the grant until that buffer signals finish, and forwards its beats with one registered cycle of latency.
- Forwards downstream backpressure to all buffers as stall.
- Signals completion once every buffer of the batch has drained.

---
 rtl/smem_output_arbiter.sv | 101 ++++++++++
 tb/tb_smem_output_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/smem_output_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS batch-result buffers onto one
// registered downstream beat stream, with grant held until the buffer finishes.
module smem_output_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  output logic [NUM_PORTS-1:0]        permit,
  input  logic [NUM_PORTS-1:0]        src_valid,
  input  logic [NUM_PORTS-1:0]        src_finish,
  input  logic [NUM_PORTS*DATA_W-1:0] src_data,
  output logic                        stall,
  input  logic                        down_almost_full,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [2:0]                  out_port,
  output logic [CNT_W-1:0]            beat_count,
  output logic                        all_done
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        gnt, rr_ptr, pick;
  logic                 pick_vld;
  logic [PW:0]          idx;
  logic [NUM_PORTS-1:0] done_mask, elig, pick_oh;
  logic [DATA_W-1:0]    sel_data;
  logic                 beat, fin;

  // Two free FIFO slots absorb the source's registered valid plus our stage.
  assign stall    = down_almost_full;
  assign elig     = req & ~done_mask;
  assign beat     = (state == GRANT) && src_valid[gnt];
  assign fin      = (state == GRANT) && src_finish[gnt];
  assign sel_data = src_data[int'(gnt)*DATA_W +: DATA_W];

  // First eligible port at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!pick_vld && elig[idx[PW-1:0]]) begin
        pick     = idx[PW-1:0];
        pick_vld = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld && !all_done) state_nxt = GRANT;
      GRANT:   if (fin) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      done_mask  <= '0;
      permit     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      beat_count <= '0;
      all_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= beat;
      if (beat) begin
        out_data   <= sel_data;
        out_port   <= 3'(gnt);
        beat_count <= beat_count + CNT_W'(1);
      end
      if (state == IDLE && state_nxt == GRANT) begin
        gnt    <= pick;
        permit <= pick_oh;
      end
      if (fin) begin
        permit         <= '0;
        done_mask[gnt] <= 1'b1;
        rr_ptr         <= (gnt == PW'(NUM_PORTS-1)) ? '0 : gnt + PW'(1);
      end
      if (&done_mask) all_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_smem_output_arbiter.sv
// Randomized scoreboard bench for smem_output_arbiter: bench-side buffer models
// feed beats; a negedge monitor pops expected beats as the DUT emits them.
module tb_smem_output_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, permit, src_valid, src_finish;
  logic [N*DW-1:0] src_data;
  logic            stall, down_almost_full, out_valid, all_done;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_port;
  logic [CW-1:0]   beat_count;

  smem_output_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .permit(permit),
    .src_valid(src_valid), .src_finish(src_finish), .src_data(src_data),
    .stall(stall), .down_almost_full(down_almost_full), .out_valid(out_valid),
    .out_data(out_data), .out_port(out_port), .beat_count(beat_count),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int port; } beat_t;
  beat_t sbq[$];
  beat_t mon_e;
  int n_cmp = 0, n_bad = 0;
  bit flush_req = 0;

  // reference model state
  bit     mdone[N];
  int     model_rr, model_total, granted_cnt;
  int     left[N], sent[N];
  logic [N-1:0] prev_permit;
  int     bp_k = -1, bp_leak, batch_push;
  bit     bp_en, mid_rst;
  int     rst_port = -1, rst_beat;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      int p = (model_rr + i) % N;
      if (req[p] && !mdone[p]) return p;
    end
    return -1;
  endfunction

  function automatic int port_of(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat: got port %0d want no beat", out_port);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_port", DW'(out_port), DW'(mon_e.port));
      end
    end
    if (flush_req) begin
      sbq.delete();
      flush_req = 0;
    end
  end

  task automatic reset_model();
    for (int p = 0; p < N; p++) begin mdone[p] = 0; left[p] = 0; sent[p] = 0; end
    model_rr = 0; model_total = 0; prev_permit = '0;
    req = '0; src_valid = '0; src_finish = '0; down_almost_full = 0; bp_k = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_permit"}, DW'(permit), '0);
    chk({tag, "_out_valid"}, DW'(out_valid), '0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_port"}, DW'(out_port), '0);
    chk({tag, "_beat_count"}, DW'(beat_count), '0);
    chk({tag, "_all_done"}, DW'(all_done), '0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    reset_model();
    src_data = '0;
    flush_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1;
  endtask

  task automatic tick();
    bit blk;
    int exp;
    @(posedge clk); #1;
    blk = stall;
    chk("stall", DW'(stall), DW'(down_almost_full));
    chk("permit_onehot0", DW'($onehot0(permit)), DW'(1));
    if (permit != '0 && prev_permit == '0) begin
      exp = model_pick();
      chk("grant_port", DW'(port_of(permit)), DW'(exp));
      chk("all_done_at_grant", DW'(all_done), '0);
      if (exp >= 0) begin mdone[exp] = 1; model_rr = (exp + 1) % N; end
      granted_cnt++;
    end
    prev_permit = permit;
    if (bp_k >= 0) begin
      bp_k++;
      if (bp_k >= 2 && out_valid) bp_leak++;
      if (bp_k == 10) begin down_almost_full = 0; bp_k = -1; end
    end
    for (int p = 0; p < N; p++) begin
      src_valid[p] = 1'b0;
      if (!permit[p]) begin
        src_valid[p] = 1'($urandom_range(0, 1));
        src_data[p*DW +: DW] = rnd();
      end else if (!src_finish[p]) begin
        if (left[p] > 0 && !blk && $urandom_range(0, 3) != 0) begin
          beat_t b;
          b.data = rnd();
          b.port = p;
          src_valid[p] = 1'b1;
          src_data[p*DW +: DW] = b.data;
          sent[p]++;
          left[p]--;
          if (p == rst_port && sent[p] == rst_beat) begin
            reset_n = 0; flush_req = 1; mid_rst = 1;
          end else begin
            sbq.push_back(b); model_total++; batch_push++;
          end
          if (left[p] == 0 && $urandom_range(0, 1) == 1) src_finish[p] = 1'b1;
        end else if (left[p] == 0) begin
          src_finish[p] = 1'b1;
        end
      end
    end
    if (bp_en && bp_k < 0 && batch_push >= 2) begin
      down_almost_full = 1; bp_k = 0; bp_en = 0;
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input int fixb, input bit bp,
                           input int rport, input int rbeat);
    int target = 0, g0, cyc = 0;
    for (int p = 0; p < N; p++)
      if (mask[p] && !mdone[p]) begin
        left[p] = (p == rport) ? 6 : (fixb >= 0) ? fixb :
                  bp ? $urandom_range(3, 8) : $urandom_range(0, 5);
        sent[p] = 0;
        src_finish[p] = (left[p] == 0);
        target++;
      end
    req = mask; bp_en = bp; bp_leak = 0; batch_push = 0;
    rst_port = rport; rst_beat = rbeat; mid_rst = 0;
    g0 = granted_cnt;
    while (!((granted_cnt - g0) == target && permit == '0) && cyc < 3000 && !mid_rst) begin
      tick();
      cyc++;
    end
    rst_port = -1;
    if (mid_rst) begin
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      reset_n = 1;
      reset_model();
      mid_rst = 0;
      return;
    end
    if (cyc >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL batch_timeout: got %0d grants want %0d", granted_cnt - g0, target);
    end
    down_almost_full = 0; bp_k = -1;
    repeat (4) tick();
    chk("beat_count", DW'(beat_count), DW'(model_total));
    chk("sb_empty", DW'(sbq.size()), '0);
    chk("all_done", DW'(all_done), DW'(mdone[0] & mdone[1] & mdone[2] & mdone[3]));
    if (bp) chk("bp_leak", DW'(bp_leak), '0);
  endtask

  initial begin
    reset_n = 0; granted_cnt = 0;
    reset_model();
    src_data = '0;
    do_reset();
    run_batch(4'b0001, 5, 0, -1, 0);
    do_reset();
    run_batch(4'b1111, 3, 0, -1, 0);
    run_batch(4'b1111, -1, 0, -1, 0);
    do_reset();
    run_batch(4'b0010, -1, 0, -1, 0);
    run_batch(4'b1011, -1, 0, -1, 0);
    do_reset();
    run_batch(4'b1111, -1, 1, -1, 0);
    do_reset();
    run_batch(4'b0101, 0, 0, -1, 0);
    do_reset();
    run_batch(4'b0100, -1, 0, 2, 3);
    run_batch(4'b0100, -1, 0, -1, 0);
    for (int it = 0; it < 20; it++) begin
      logic [N-1:0] m;
      do_reset();
      m = N'($urandom_range(1, 15));
      run_batch(m, -1, 1'($urandom_range(0, 1)), -1, 0);
      if ($urandom_range(0, 1) == 1) run_batch(4'b1111, -1, 0, -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
